// File: rtl/td4_pkg.sv
// Shared definitions for the TD4-style fetch path: FSM encodings, default
// widths and the opcode/immediate split of an instruction word.
package td4_pkg;

    localparam int TD4_ADDR_W = 4;
    localparam int TD4_DATA_W = 8;

    localparam int OP_MSB = 7;
    localparam int OP_LSB = 4;
    localparam int IM_MSB = 3;
    localparam int IM_LSB = 0;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_PROGRAM = 2'b01,
        ST_EXEC    = 2'b10,
        ST_HALT    = 2'b11
    } state_e;

    function automatic logic [OP_MSB-OP_LSB:0] instr_op(input logic [TD4_DATA_W-1:0] instr);
        return instr[OP_MSB:OP_LSB];
    endfunction

    function automatic logic [IM_MSB-IM_LSB:0] instr_im(input logic [TD4_DATA_W-1:0] instr);
        return instr[IM_MSB:IM_LSB];
    endfunction

endpackage

// File: rtl/prog_mem.sv
// Program store: one register per word, synchronous write, combinational read,
// every word cleared by the asynchronous reset.
module prog_mem
    import td4_pkg::*;
#(
    parameter int ADDR_W = TD4_ADDR_W,
    parameter int DATA_W = TD4_DATA_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Per-word registers so the whole array can be cleared in one reset.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                mem_q[gi] <= '0;
            end else if (we_i && (waddr_i == ADDR_W'(gi))) begin
                mem_q[gi] <= wdata_i;
            end
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: load-mode programming of the instruction store and
// a one-instruction-per-cycle PC sequencer with jump and self-jump halt.
module fetch_unit
    import td4_pkg::*;
#(
    parameter int ADDR_W = TD4_ADDR_W,
    parameter int DATA_W = TD4_DATA_W
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              PROG_EN,
    input  logic              PROG_WE,
    input  logic [ADDR_W-1:0] PROG_ADDR,
    input  logic [DATA_W-1:0] PROG_DATA,
    output logic              PROG_ACK,
    input  logic              RUN,
    input  logic              JUMP,
    input  logic [ADDR_W-1:0] JUMP_ADDR,
    output logic [3:0]        OP,
    output logic [3:0]        IM,
    output logic [ADDR_W-1:0] PC,
    output logic              INSTR_VALID,
    output logic [1:0]        STATE
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              ack_q;
    logic              mem_we;
    logic [DATA_W-1:0] rd_data;
    logic              fetch_live;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ack_q   <= mem_we;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        mem_we  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (PROG_EN) begin
                    state_d = ST_PROGRAM;
                end else if (RUN) begin
                    state_d = ST_EXEC;
                end
            end
            ST_PROGRAM: begin
                // A write on the same edge that leaves load mode still lands.
                mem_we = PROG_WE;
                if (!PROG_EN) begin
                    state_d = ST_IDLE;
                    pc_d    = '0;
                end
            end
            ST_EXEC: begin
                if (!RUN) begin
                    state_d = ST_IDLE;
                end else if (JUMP) begin
                    if (JUMP_ADDR == pc_q) begin
                        state_d = ST_HALT;
                    end else begin
                        pc_d = JUMP_ADDR;
                    end
                end else begin
                    pc_d = pc_q + ADDR_W'(1);
                end
            end
            ST_HALT: begin
                if (PROG_EN) begin
                    state_d = ST_PROGRAM;
                    pc_d    = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    prog_mem #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_prog_mem (
        .clk_i   (CLK),
        .rst_i   (RESET),
        .we_i    (mem_we),
        .waddr_i (PROG_ADDR),
        .wdata_i (PROG_DATA),
        .raddr_i (pc_q),
        .rdata_o (rd_data)
    );

    // HALT keeps presenting the parked instruction, but it is no longer live.
    assign fetch_live  = (state_q == ST_EXEC) || (state_q == ST_HALT);
    assign OP          = fetch_live ? instr_op(rd_data) : 4'h0;
    assign IM          = fetch_live ? instr_im(rd_data) : 4'h0;
    assign INSTR_VALID = (state_q == ST_EXEC);
    assign PC          = pc_q;
    assign STATE       = state_q;
    assign PROG_ACK    = ack_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: programming/ack, sequential fetch with wrap,
// jump, pause/resume, self-jump halt, mode priority and asynchronous reset.
module tb_fetch_unit;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       PROG_EN, PROG_WE, RUN, JUMP;
    logic [3:0] PROG_ADDR, JUMP_ADDR;
    logic [7:0] PROG_DATA;
    logic       PROG_ACK, INSTR_VALID;
    logic [3:0] OP, IM, PC;
    logic [1:0] STATE;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 CLK = ~CLK;

    fetch_unit #(.ADDR_W(4), .DATA_W(8)) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .PROG_EN     (PROG_EN),
        .PROG_WE     (PROG_WE),
        .PROG_ADDR   (PROG_ADDR),
        .PROG_DATA   (PROG_DATA),
        .PROG_ACK    (PROG_ACK),
        .RUN         (RUN),
        .JUMP        (JUMP),
        .JUMP_ADDR   (JUMP_ADDR),
        .OP          (OP),
        .IM          (IM),
        .PC          (PC),
        .INSTR_VALID (INSTR_VALID),
        .STATE       (STATE)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_core(input string tag, input logic [1:0] st, input logic [3:0] pc,
                              input logic [3:0] op, input logic [3:0] im, input logic vld);
        check({tag, ".state"}, 16'(STATE), 16'(st));
        check({tag, ".pc"},    16'(PC),    16'(pc));
        check({tag, ".op"},    16'(OP),    16'(op));
        check({tag, ".im"},    16'(IM),    16'(im));
        check({tag, ".valid"}, 16'(INSTR_VALID), 16'(vld));
        $display("step %-14s state=%0d pc=%0d op=%0h im=%0h valid=%0b ack=%0b",
                 tag, STATE, PC, OP, IM, INSTR_VALID, PROG_ACK);
    endtask

    initial begin
        RESET = 1'b1; PROG_EN = 0; PROG_WE = 0; RUN = 0; JUMP = 0;
        PROG_ADDR = 0; PROG_DATA = 0; JUMP_ADDR = 0;
        #12;
        check_core("reset", 2'd0, 4'd0, 4'd0, 4'd0, 1'b0);
        check("reset.ack", 16'(PROG_ACK), 16'd0);
        RESET = 1'b0;

        // Program 0xB3 at address 2, ack follows the write edge for one cycle.
        PROG_EN = 1; step();
        check_core("prog_enter", 2'd1, 4'd0, 4'd0, 4'd0, 1'b0);
        check("prog_enter.ack", 16'(PROG_ACK), 16'd0);
        PROG_WE = 1; PROG_ADDR = 4'd2; PROG_DATA = 8'hB3; step();
        check("wr_b3.ack", 16'(PROG_ACK), 16'd1);
        PROG_WE = 0; step();
        check("wr_b3.ack_drop", 16'(PROG_ACK), 16'd0);
        PROG_EN = 0; step();
        check_core("prog_exit", 2'd0, 4'd0, 4'd0, 4'd0, 1'b0);
        PROG_WE = 1; PROG_DATA = 8'h55; step();
        check("idle_we.ack", 16'(PROG_ACK), 16'd0);
        check("idle_we.state", 16'(STATE), 16'd0);
        PROG_WE = 0;
        RUN = 1; step();
        check_core("exec_pc0", 2'd2, 4'd0, 4'd0, 4'd0, 1'b1);
        step();
        check_core("exec_pc1", 2'd2, 4'd1, 4'd0, 4'd0, 1'b1);
        step();
        check_core("exec_pc2_b3", 2'd2, 4'd2, 4'hB, 4'h3, 1'b1);
        RUN = 0; step();
        check_core("pause_pc2", 2'd0, 4'd2, 4'd0, 4'd0, 1'b0);

        // Load mem[i] = {i,i}; the last write coincides with leaving load mode.
        PROG_EN = 1; step();
        check_core("reprog_enter", 2'd1, 4'd2, 4'd0, 4'd0, 1'b0);
        for (int i = 0; i < 15; i++) begin
            PROG_WE = 1; PROG_ADDR = 4'(i); PROG_DATA = {4'(i), 4'(i)}; step();
            check($sformatf("pat_wr%0d.ack", i), 16'(PROG_ACK), 16'd1);
        end
        PROG_EN = 0; PROG_WE = 1; PROG_ADDR = 4'd15; PROG_DATA = 8'hFF; step();
        check("last_wr.ack", 16'(PROG_ACK), 16'd1);
        check_core("last_wr", 2'd0, 4'd0, 4'd0, 4'd0, 1'b0);
        PROG_WE = 0; step();
        check("after_last.ack", 16'(PROG_ACK), 16'd0);

        // Sequential fetch through the 15 -> 0 wrap, ending at PC 3.
        RUN = 1; step();
        check_core("seq_pc0", 2'd2, 4'd0, 4'd0, 4'd0, 1'b1);
        for (int k = 1; k < 20; k++) begin
            step();
            check_core($sformatf("seq_k%0d", k), 2'd2, 4'(k % 16), 4'(k % 16), 4'(k % 16), 1'b1);
        end

        JUMP = 1; JUMP_ADDR = 4'd9; step();
        check_core("jump_3to9", 2'd2, 4'd9, 4'd9, 4'd9, 1'b1);
        JUMP_ADDR = 4'd4; step();
        check_core("jump_9to4", 2'd2, 4'd4, 4'd4, 4'd4, 1'b1);

        // Pause at 4, ignored jump while idle, resume at 4.
        JUMP = 0; RUN = 0; step();
        check_core("pause_pc4", 2'd0, 4'd4, 4'd0, 4'd0, 1'b0);
        JUMP = 1; JUMP_ADDR = 4'd12; step();
        check_core("idle_jump", 2'd0, 4'd4, 4'd0, 4'd0, 1'b0);
        JUMP = 0; RUN = 1; step();
        check_core("resume_pc4", 2'd2, 4'd4, 4'd4, 4'd4, 1'b1);
        step();
        check_core("run_pc5", 2'd2, 4'd5, 4'd5, 4'd5, 1'b1);

        // Self-jump halt at 7, then exit to PROGRAM.
        JUMP = 1; JUMP_ADDR = 4'd7; step();
        check_core("jump_5to7", 2'd2, 4'd7, 4'd7, 4'd7, 1'b1);
        step();
        check_core("halt", 2'd3, 4'd7, 4'd7, 4'd7, 1'b0);
        JUMP = 0; step();
        check_core("halt_hold", 2'd3, 4'd7, 4'd7, 4'd7, 1'b0);
        PROG_WE = 1; PROG_ADDR = 4'd0; PROG_DATA = 8'hAA; step();
        check("halt_we.ack", 16'(PROG_ACK), 16'd0);
        check("halt_we.state", 16'(STATE), 16'd3);
        PROG_WE = 0; PROG_EN = 1; step();
        check_core("halt_exit", 2'd1, 4'd0, 4'd0, 4'd0, 1'b0);

        // PROG_EN beats RUN in IDLE.
        PROG_EN = 0; step();
        check_core("idle_again", 2'd0, 4'd0, 4'd0, 4'd0, 1'b0);
        PROG_EN = 1; step();
        check_core("priority", 2'd1, 4'd0, 4'd0, 4'd0, 1'b0);
        PROG_EN = 0; step();
        check_core("prio_exit", 2'd0, 4'd0, 4'd0, 4'd0, 1'b0);
        step();
        check_core("run2_pc0", 2'd2, 4'd0, 4'd0, 4'd0, 1'b1);
        for (int k = 1; k < 6; k++) begin
            step();
            check_core($sformatf("run2_k%0d", k), 2'd2, 4'(k), 4'(k), 4'(k), 1'b1);
        end

        // Asynchronous reset mid-EXEC at PC 5 clears state, PC and memory.
        #2; RESET = 1; #1;
        check_core("async_rst", 2'd0, 4'd0, 4'd0, 4'd0, 1'b0);
        check("async_rst.ack", 16'(PROG_ACK), 16'd0);
        #3; RESET = 0;
        step();
        check_core("post_rst_pc0", 2'd2, 4'd0, 4'd0, 4'd0, 1'b1);
        for (int k = 1; k < 16; k++) begin
            step();
            check_core($sformatf("clr_k%0d", k), 2'd2, 4'(k), 4'd0, 4'd0, 1'b1);
        end
        RUN = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
